gppcu_cmd_bridge: RTL and testbench
===================================

Name: gppcu_cmd_bridge

Overview:
- Upstream host-side stage of the GPPCU instruction-queue test block. Accepts host commands (wparam/lparam/command + data) on a valid/ready interface and buffers them in a FIFO.
- Replays each command onto the queue's 32-bit iCMD/iDATA bus, generating the software-style opclk pulse (iCMD[31]) with guaranteed setup and hold.
- For read-type commands, captures the queue's oDATA into a single-entry response buffer for the host.

Parameters:
- FIFO_ABW, 4, log2 of command FIFO depth (depth 16)
- SETUP_CYC, 1, cycles opclk held low with cmd/data stable before the rising edge (>=1)
- HIGH_CYC, 1, cycles opclk held high (>=1)

Ports:
- iACLK  in  1  system clock
- iRST  in  1  synchronous reset, active high
- iHOST_VALID  in  1  host command valid
- oHOST_READY  out  1  FIFO can accept a command
- iHOST_CMD  in  31  {wparam[30:24], lparam[23:16], command[15:0]}
- iHOST_DATA  in  32  command data (instruction/write word)
- oRESP_VALID  out  1  response buffer holds captured read data
- iRESP_READY  in  1  host consumes response
- oRESP_DATA  out  32  captured read/status word
- oCMD  out  32  to queue iCMD: {opclk, wparam, lparam, command}
- oDATA  out  32  to queue iDATA
- iRDATA  in  32  from queue oDATA
- oBUSY  out  1  FIFO non-empty or FSM not IDLE
- oLEVEL  out  FIFO_ABW+1  FIFO occupancy

Behaviour:
- Reset (sync, 1 edge): FIFO emptied, FSM=IDLE, oCMD=0, oDATA=0, oRESP_VALID=0, oRESP_DATA=0, oLEVEL=0, oBUSY=0. Reset mid-pulse drops opclk to 0 at that edge; the in-flight command is lost.
- FIFO:
  - oHOST_READY = !full; push on iHOST_VALID & oHOST_READY. No push-while-full even if a pop occurs that cycle.
  - No bypass: a pushed entry is poppable the next cycle.
  - Order preserved; pointers wrap modulo depth.
- Read-type command: wparam==1 (RDL) or wparam==4 (OPR_COMMAND/status). All others are writes.
- Issue condition: FIFO non-empty AND (command is write OR oRESP_VALID==0). A blocked read at the head stalls all later commands; no reordering.
- FSM states:
  - IDLE: opclk=0; oCMD[30:0]/oDATA hold their last values. If the issue condition holds: pop, load oCMD[30:0]/oDATA, go SETUP.
  - SETUP: opclk=0, for SETUP_CYC cycles, then go HIGH.
  - HIGH: opclk=1, for HIGH_CYC cycles, then go TAIL.
  - TAIL: opclk=0, one cycle; cmd/data still held (hold time). If read: at end of the cycle, oRESP_DATA<=iRDATA and oRESP_VALID<=1. If the issue condition holds (evaluated with the updated response state, i.e. a read just captured blocks a following read): pop directly to SETUP; else go IDLE.
- Cycle counts (defaults):
  - Back-to-back spacing: SETUP_CYC+HIGH_CYC+1 = 3 cycles per command.
  - Latency: opclk is high in the 2nd cycle after the accepting edge of an empty-bridge push.
- Response buffer:
  - Cleared on oRESP_VALID & iRESP_READY.
  - Consume and capture never coincide, because reads issue only when empty.
- oLEVEL counts FIFO entries only, excluding the in-flight command.
- opclk is a registered output, glitch-free; oCMD[30:0] never changes while opclk=1 or during TAIL.

Decomposition:
- Shared package gppcu_cmd_pkg: OPR_INSTR=0, OPR_RDL=1, OPR_WRL=2, OPR_WRG=3, OPR_COMMAND=4; LPM_RUNSTOP=0, LPM_NUMCYCLE=1, LPM_SZPERCYCLE=2, LPM_RESETPRG=3; FSM state encoding; field offsets of iCMD.
- One sub-module, gppcu_cmd_fifo: synchronous FIFO, width 63, parameter ABW, with full/empty/level outputs.
- The FSM and response buffer live in the top module.

Test Plan:
- Single write: push cmd 0x02010005, data 0x1234 at edge 0 -> oCMD[30:0]=0x02010005 and oDATA=0x1234 from edge 1; oCMD[31]=1 only between edges 2-3; oBUSY low after edge 4.
- Read capture: push wparam=1/lparam=1/cmd=3; model iRDATA=0xDEAD0003 valid from opclk rise -> oRESP_VALID=1 after the TAIL edge, oRESP_DATA=0xDEAD0003; iRESP_READY=1 -> valid drops next edge.
- Read stall: push 2 status reads (wparam=4), hold iRESP_READY=0 -> exactly one opclk pulse; second pulse starts 1 cycle after iRESP_READY pulse; writes queued behind it also wait.
- Burst/full: push 20 writes back-to-back with data=index -> oHOST_READY deasserts when oLEVEL=16; all 20 emerge in order, 20 pulses, exactly 3 cycles apart, no gaps.
- Reset mid-operation: assert iRST during HIGH with 5 entries queued -> next edge oCMD=0, oLEVEL=0, oHOST_READY=1; no further pulses until new push.
- Timing parameters: SETUP_CYC=3, HIGH_CYC=2 -> opclk low 3 cycles and high 2 cycles per command, spacing 6 cycles, cmd/data stable throughout.

Source files
------------

// File: rtl/gppcu_cmd_pkg.sv
// gppcu_cmd_pkg
// Shared definitions for the GPPCU host command bridge: wparam opcodes,
// lparam sub-codes, field offsets of the queue iCMD word, FIFO entry
// layout and the replay FSM state encoding.
package gppcu_cmd_pkg;

    // wparam opcodes
    localparam logic [6:0] OPR_INSTR   = 7'd0;
    localparam logic [6:0] OPR_RDL     = 7'd1;
    localparam logic [6:0] OPR_WRL     = 7'd2;
    localparam logic [6:0] OPR_WRG     = 7'd3;
    localparam logic [6:0] OPR_COMMAND = 7'd4;

    // lparam sub-codes for OPR_COMMAND
    localparam logic [7:0] LPM_RUNSTOP    = 8'd0;
    localparam logic [7:0] LPM_NUMCYCLE   = 8'd1;
    localparam logic [7:0] LPM_SZPERCYCLE = 8'd2;
    localparam logic [7:0] LPM_RESETPRG   = 8'd3;

    // iCMD field offsets
    localparam int CMD_OPCLK_BIT = 31;
    localparam int CMD_WPARAM_LSB = 24;
    localparam int CMD_LPARAM_LSB = 16;
    localparam int CMD_COMMAND_LSB = 0;

    // Host command / data widths and FIFO entry layout {cmd, data}
    localparam int HCMD_W  = 31;
    localparam int HDATA_W = 32;
    localparam int ENTRY_W = HCMD_W + HDATA_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_TAIL  = 2'd3
    } bridge_state_e;

    // Reads return a word through the queue's oDATA; everything else is a write.
    function automatic logic is_read_cmd(input logic [HCMD_W-1:0] cmd);
        return (cmd[30:24] == OPR_RDL) || (cmd[30:24] == OPR_COMMAND);
    endfunction

endpackage

// File: rtl/gppcu_cmd_fifo.sv
// gppcu_cmd_fifo
// Synchronous FIFO of 2**ABW entries, no bypass (a pushed entry is visible
// the cycle after the push). Push is refused while full even if a pop
// happens in the same cycle.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_push, i_wdata     write request and entry
//   i_pop               read request (ignored when empty)
//   o_rdata             head entry
//   o_full, o_empty     status
//   o_level             occupancy 0..2**ABW
module gppcu_cmd_fifo #(
    parameter int ABW = 4,
    parameter int W   = 63
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty,
    output logic [ABW:0] o_level
);
    localparam int DEPTH = 1 << ABW;
    localparam logic [ABW:0] LVL_FULL = (ABW+1)'(DEPTH);

    logic [W-1:0]   r_mem [DEPTH];
    logic [ABW-1:0] r_wptr;
    logic [ABW-1:0] r_rptr;
    logic [ABW:0]   r_level;
    logic           w_push;
    logic           w_pop;

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_full  = (r_level == LVL_FULL);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rptr];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/gppcu_cmd_bridge.sv
// gppcu_cmd_bridge
// Host-side front end of the GPPCU instruction queue. Host commands are
// buffered in a FIFO and replayed onto iCMD/iDATA with a software-style
// opclk pulse on iCMD[31] (SETUP_CYC low, HIGH_CYC high, one hold cycle).
// Read-type commands (RDL, OPR_COMMAND) capture the queue's oDATA at the end
// of the hold cycle into a one-entry response buffer.
// Ports:
//   iACLK, iRST                      clock, synchronous active-high reset
//   iHOST_VALID/oHOST_READY          host command handshake
//   iHOST_CMD[30:0], iHOST_DATA      {wparam, lparam, command}, data word
//   oRESP_VALID/iRESP_READY          response handshake
//   oRESP_DATA                       captured read word
//   oCMD, oDATA                      to queue iCMD / iDATA
//   iRDATA                           from queue oDATA
//   oBUSY                            FIFO non-empty or a command in flight
//   oLEVEL                           FIFO occupancy (in-flight excluded)
module gppcu_cmd_bridge
    import gppcu_cmd_pkg::*;
#(
    parameter int FIFO_ABW  = 4,
    parameter int SETUP_CYC = 1,
    parameter int HIGH_CYC  = 1
) (
    input  logic                iACLK,
    input  logic                iRST,
    input  logic                iHOST_VALID,
    output logic                oHOST_READY,
    input  logic [30:0]         iHOST_CMD,
    input  logic [31:0]         iHOST_DATA,
    output logic                oRESP_VALID,
    input  logic                iRESP_READY,
    output logic [31:0]         oRESP_DATA,
    output logic [31:0]         oCMD,
    output logic [31:0]         oDATA,
    input  logic [31:0]         iRDATA,
    output logic                oBUSY,
    output logic [FIFO_ABW:0]   oLEVEL
);
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] HIGH_LAST  = CNT_W'(HIGH_CYC - 1);

    bridge_state_e        r_state;
    bridge_state_e        w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 r_opclk;
    logic [HCMD_W-1:0]    r_cmd;
    logic [HDATA_W-1:0]   r_data;
    logic                 r_resp_valid;
    logic [31:0]          r_resp_data;

    logic [ENTRY_W-1:0]   w_head;
    logic [HCMD_W-1:0]    w_head_cmd;
    logic [HDATA_W-1:0]   w_head_data;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_capture;
    logic                 w_resp_valid_nxt;
    logic                 w_issue_idle;
    logic                 w_issue_tail;

    gppcu_cmd_fifo #(
        .ABW (FIFO_ABW),
        .W   (ENTRY_W)
    ) u_fifo (
        .i_clk   (iACLK),
        .i_rst   (iRST),
        .i_push  (iHOST_VALID),
        .i_wdata ({iHOST_CMD, iHOST_DATA}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (oLEVEL)
    );

    assign w_head_cmd  = w_head[ENTRY_W-1:HDATA_W];
    assign w_head_data = w_head[HDATA_W-1:0];

    // Capture happens on the edge that ends the hold cycle of a read.
    assign w_capture        = (r_state == ST_TAIL) && is_read_cmd(r_cmd);
    assign w_resp_valid_nxt = w_capture | (r_resp_valid & ~iRESP_READY);

    // A read may only go out when the response buffer will be free for it.
    // From TAIL the decision uses the post-edge buffer state, so a read
    // captured right now blocks a directly following read.
    assign w_issue_idle = ~w_empty & (~is_read_cmd(w_head_cmd) | ~r_resp_valid);
    assign w_issue_tail = ~w_empty & (~is_read_cmd(w_head_cmd) | ~w_resp_valid_nxt);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_issue_idle) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SETUP: begin
                if (r_cnt == SETUP_LAST) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_HIGH: begin
                if (r_cnt == HIGH_LAST) begin
                    w_state_nxt = ST_TAIL;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_TAIL: begin
                if (w_issue_tail) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // opclk is registered from the next state so it is glitch-free and lines
    // up exactly with the HIGH state.
    always_ff @(posedge iACLK) begin
        if (iRST) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_opclk      <= 1'b0;
            r_cmd        <= '0;
            r_data       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_opclk      <= (w_state_nxt == ST_HIGH);
            r_resp_valid <= w_resp_valid_nxt;
            if (w_pop) begin
                r_cmd  <= w_head_cmd;
                r_data <= w_head_data;
            end
            if (w_capture) begin
                r_resp_data <= iRDATA;
            end
        end
    end

    assign oHOST_READY = ~w_full;
    assign oCMD        = {r_opclk, r_cmd};
    assign oDATA       = r_data;
    assign oRESP_VALID = r_resp_valid;
    assign oRESP_DATA  = r_resp_data;
    assign oBUSY       = ~w_empty | (r_state != ST_IDLE);

endmodule

// File: tb/tb_gppcu_cmd_bridge.sv
// tb_gppcu_cmd_bridge
// Directed bench for gppcu_cmd_bridge: default-timing instance plus a second
// instance with SETUP_CYC=3 / HIGH_CYC=2.
module tb_gppcu_cmd_bridge;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // default-parameter DUT
    logic        rst;
    logic        hvalid;
    logic        hready;
    logic [30:0] hcmd;
    logic [31:0] hdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata_resp;
    logic [31:0] ocmd;
    logic [31:0] odata;
    logic [31:0] qrdata;
    logic        busy;
    logic [4:0]  level;

    // SETUP_CYC=3, HIGH_CYC=2 DUT
    logic        p_rst;
    logic        p_hvalid;
    logic        p_hready;
    logic [30:0] p_hcmd;
    logic [31:0] p_hdata;
    logic        p_rvalid;
    logic [31:0] p_rdata_resp;
    logic [31:0] p_ocmd;
    logic [31:0] p_odata;
    logic        p_busy;
    logic [4:0]  p_level;

    gppcu_cmd_bridge dut (
        .iACLK       (clk),
        .iRST        (rst),
        .iHOST_VALID (hvalid),
        .oHOST_READY (hready),
        .iHOST_CMD   (hcmd),
        .iHOST_DATA  (hdata),
        .oRESP_VALID (rvalid),
        .iRESP_READY (rready),
        .oRESP_DATA  (rdata_resp),
        .oCMD        (ocmd),
        .oDATA       (odata),
        .iRDATA      (qrdata),
        .oBUSY       (busy),
        .oLEVEL      (level)
    );

    gppcu_cmd_bridge #(
        .FIFO_ABW  (4),
        .SETUP_CYC (3),
        .HIGH_CYC  (2)
    ) dut_p (
        .iACLK       (clk),
        .iRST        (p_rst),
        .iHOST_VALID (p_hvalid),
        .oHOST_READY (p_hready),
        .iHOST_CMD   (p_hcmd),
        .iHOST_DATA  (p_hdata),
        .oRESP_VALID (p_rvalid),
        .iRESP_READY (1'b0),
        .oRESP_DATA  (p_rdata_resp),
        .oCMD        (p_ocmd),
        .oDATA       (p_odata),
        .iRDATA      (32'h0),
        .oBUSY       (p_busy),
        .oLEVEL      (p_level)
    );

    // Queue model: read word = {16'hDEAD, command}, valid from the opclk rise.
    always @(posedge clk) begin
        if (ocmd[31]) qrdata <= {16'hDEAD, ocmd[15:0]};
    end

    // Pulse monitor: records oDATA, oCMD and cycle number of every opclk rise.
    int          cyc = 0;
    int          n_pulse = 0;
    logic        prev_op = 1'b0;
    logic [31:0] pd   [64];
    int          pcyc [64];
    always @(negedge clk) begin
        cyc     <= cyc + 1;
        prev_op <= ocmd[31];
        if (ocmd[31] && !prev_op) begin
            pd[n_pulse % 64]   <= odata;
            pcyc[n_pulse % 64] <= cyc;
            n_pulse            <= n_pulse + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int          base;
        int          pushed;
        int          guard;
        bit          acc;
        bit          saw_full;
        bit          found;
        logic [30:0] cmd_a;
        logic [30:0] cmd_b;
        logic [12:0] p_exp;

        rst = 1'b1; hvalid = 1'b0; hcmd = '0; hdata = '0; rready = 1'b0;
        p_rst = 1'b1; p_hvalid = 1'b0; p_hcmd = '0; p_hdata = '0;
        tick();
        tick();
        rst = 1'b0;
        p_rst = 1'b0;

        // reset state
        chk("rst_ocmd",   ocmd, 0);
        chk("rst_odata",  odata, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata",  rdata_resp, 0);
        chk("rst_level",  level, 0);
        chk("rst_busy",   busy, 0);
        chk("rst_ready",  hready, 1);

        // single write
        hvalid = 1'b1; hcmd = 31'h02010005; hdata = 32'h1234;
        tick();                                    // edge 0
        hvalid = 1'b0;
        chk("w_level_e0", level, 1);
        chk("w_op_e0",    ocmd[31], 0);
        tick();                                    // edge 1
        chk("w_cmd_e1",   ocmd[30:0], 31'h02010005);
        chk("w_data_e1",  odata, 32'h1234);
        chk("w_op_e1",    ocmd[31], 0);
        chk("w_level_e1", level, 0);
        tick();                                    // edge 2
        chk("w_op_e2",    ocmd[31], 1);
        tick();                                    // edge 3
        chk("w_op_e3",    ocmd[31], 0);
        chk("w_cmd_e3",   ocmd[30:0], 31'h02010005);
        chk("w_busy_e3",  busy, 1);
        tick();                                    // edge 4
        chk("w_busy_e4",  busy, 0);

        // read capture
        hvalid = 1'b1; hcmd = 31'h01010003; hdata = 32'h0;
        tick();
        hvalid = 1'b0;
        tick(); tick(); tick();
        chk("r_valid_e3", rvalid, 0);
        tick();
        chk("r_valid_e4", rvalid, 1);
        chk("r_data_e4",  rdata_resp, 32'hDEAD0003);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("r_valid_drop", rvalid, 0);

        // read stall: two status reads then a write
        base = n_pulse;
        hvalid = 1'b1; hcmd = 31'h04000010; hdata = 32'hA;
        tick();
        hcmd = 31'h04000011; hdata = 32'hB;
        tick();
        hcmd = 31'h02000020; hdata = 32'h20;
        tick();
        hvalid = 1'b0;
        repeat (20) tick();
        chk("s_one_pulse", n_pulse - base, 1);
        chk("s_valid",     rvalid, 1);
        chk("s_data0",     rdata_resp, 32'hDEAD0010);
        chk("s_level",     level, 2);
        rready = 1'b1;
        tick();                                    // edge k
        rready = 1'b0;
        chk("s_valid_clr", rvalid, 0);
        tick();                                    // k+1
        chk("s_op_k1",     ocmd[31], 0);
        chk("s_cmd_k1",    ocmd[30:0], 31'h04000011);
        tick();                                    // k+2
        chk("s_op_k2",     ocmd[31], 1);
        tick(); tick();                            // k+4
        chk("s_valid_k4",  rvalid, 1);
        chk("s_data1",     rdata_resp, 32'hDEAD0011);
        tick();                                    // k+5
        chk("s_wr_op",     ocmd[31], 1);
        chk("s_wr_cmd",    ocmd[30:0], 31'h02000020);
        tick(); tick();
        chk("s_idle",      busy, 0);

        // burst/full: blocked read at head, 20 writes behind it
        base = n_pulse;
        hvalid = 1'b1; hcmd = 31'h04000030; hdata = 32'h30;
        tick();
        pushed = 0; guard = 0; saw_full = 1'b0;
        while (pushed < 20 && guard < 300) begin
            hvalid = 1'b1;
            hcmd   = {7'd2, 8'd0, 16'(pushed)};
            hdata  = 32'(pushed);
            acc    = hready;
            if (level == 5'd16 && !saw_full) begin
                saw_full = 1'b1;
                chk("b_ready_full", hready, 0);
                rready = 1'b1;
            end else begin
                rready = 1'b0;
            end
            tick();
            if (acc) pushed++;
            guard++;
        end
        hvalid = 1'b0;
        rready = 1'b0;
        chk("b_saw_full", saw_full, 1);
        chk("b_pushed",   pushed, 20);
        guard = 0;
        while (busy && guard < 300) begin
            tick();
            guard++;
        end
        chk("b_drained", busy, 0);
        chk("b_pulses",  n_pulse - base, 21);
        chk("b_rd_data", pd[base % 64], 32'h30);
        chk("b_resp",    rdata_resp, 32'hDEAD0030);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("b_order%0d", i), pd[(base + 1 + i) % 64], 32'(i));
        end
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("b_space%0d", i),
                pcyc[(base + 1 + i) % 64] - pcyc[(base + i) % 64], 3);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;

        // reset mid-operation
        for (int i = 0; i < 8; i++) begin
            hvalid = 1'b1; hcmd = {7'd3, 8'd0, 16'(i)}; hdata = 32'(i);
            tick();
        end
        hvalid = 1'b0;
        found = 1'b0;
        for (int g = 0; g < 20; g++) begin
            if (ocmd[31] && level == 5'd5) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("x_high_lvl5", found, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("x_ocmd",  ocmd, 0);
        chk("x_level", level, 0);
        chk("x_ready", hready, 1);
        chk("x_busy",  busy, 0);
        base = n_pulse;
        repeat (10) tick();
        chk("x_no_pulse", n_pulse - base, 0);

        // SETUP_CYC=3, HIGH_CYC=2
        cmd_a = {7'd3, 8'd2, 16'h000A};
        cmd_b = {7'd3, 8'd2, 16'h000B};
        p_exp = 13'h0C30;                          // opclk high after edges 4,5,10,11
        p_hvalid = 1'b1; p_hcmd = cmd_a; p_hdata = 32'hA;
        tick();                                    // edge 0
        p_hcmd = cmd_b; p_hdata = 32'hB;
        tick();                                    // edge 1
        p_hvalid = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            chk($sformatf("p_op%0d", j), p_ocmd[31], p_exp[j]);
            chk($sformatf("p_cmd%0d", j), p_ocmd[30:0], (j <= 6) ? cmd_a : cmd_b);
            chk($sformatf("p_dat%0d", j), p_odata, (j <= 6) ? 32'hA : 32'hB);
            tick();
        end
        chk("p_idle", p_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
